// File: rtl/acs_unit.sv
// rtl/acs_unit.sv - add-compare-select unit for a K=3 rate-1/2 Viterbi decoder
// Define ACS_NORM_EN for MSB path-metric normalisation; the default build saturates metrics.
module acs_unit #(
  parameter int FRAME_LEN = 8,
  parameter int PM_W      = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_acs,
  input  logic            sym_valid,
  input  logic [1:0]      sym,
  output logic            prv_st_00,
  output logic            prv_st_01,
  output logic            prv_st_10,
  output logic            prv_st_11,
  output logic            en_mem,
  output logic            busy,
  output logic            frame_done,
  output logic [1:0]      best_st,
  output logic [PM_W-1:0] pm_00,
  output logic [PM_W-1:0] pm_01,
  output logic [PM_W-1:0] pm_10,
  output logic [PM_W-1:0] pm_11
);

  localparam int               CNT_W    = $clog2(FRAME_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [PM_W-1:0]  PM_INIT  = PM_W'(16);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [PM_W-1:0]  r_pm [4];
  logic [3:0]       r_dec;
  logic             r_en_mem;
  logic             r_busy;
  logic             r_frame_done;
  logic [1:0]       r_best;

  logic [PM_W:0]    w_min [4];
  logic [3:0]       w_dec;
  logic [PM_W-1:0]  w_new [4];
  logic [1:0]       w_best;
  logic [PM_W-1:0]  w_best_pm;

  function automatic logic [PM_W:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return (PM_W+1)'(x[1]) + (PM_W+1)'(x[0]);
  endfunction

  // Next state {u,a} is reached from {a,0} and {a,1}; expected pair is {u^a^b, u^b}.
  for (genvar ns = 0; ns < 4; ns++) begin : g_acs
    localparam int         U    = ns / 2;
    localparam int         A    = ns % 2;
    localparam logic [1:0] EXP0 = 2'(((U ^ A) * 2) + U);
    localparam logic [1:0] EXP1 = 2'(((U ^ A ^ 1) * 2) + (U ^ 1));
    logic [PM_W:0] w_sum0;
    logic [PM_W:0] w_sum1;
    assign w_sum0     = {1'b0, r_pm[2*A]}     + hamming(sym, EXP0);
    assign w_sum1     = {1'b0, r_pm[2*A + 1]} + hamming(sym, EXP1);
    assign w_dec[ns]  = w_sum1 < w_sum0;
    assign w_min[ns]  = w_dec[ns] ? w_sum1 : w_sum0;
  end

`ifdef ACS_NORM_EN
  localparam logic [PM_W:0] PM_HALF = (PM_W+1)'(1) << (PM_W - 1);
  logic w_all_hi;

  always_comb begin
    w_all_hi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_min[i] < PM_HALF) w_all_hi = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      w_new[i] = w_all_hi ? PM_W'(w_min[i] - PM_HALF) : PM_W'(w_min[i]);
    end
  end
`else
  localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_new[i] = (w_min[i] > PM_MAX) ? PM_MAX[PM_W-1:0] : w_min[i][PM_W-1:0];
    end
  end
`endif

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_best    = 2'd0;
    w_best_pm = r_pm[0];
    for (int i = 1; i < 4; i++) begin
      if (r_pm[i] < w_best_pm) begin
        w_best    = 2'(i);
        w_best_pm = r_pm[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_pm[0]      <= '0;
      r_pm[1]      <= PM_INIT;
      r_pm[2]      <= PM_INIT;
      r_pm[3]      <= PM_INIT;
      r_dec        <= '0;
      r_en_mem     <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_best       <= '0;
    end else begin
      r_en_mem     <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en_acs) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_count <= '0;
            r_pm[0] <= '0;
            r_pm[1] <= PM_INIT;
            r_pm[2] <= PM_INIT;
            r_pm[3] <= PM_INIT;
          end
        end
        RUN: begin
          if (sym_valid) begin
            for (int i = 0; i < 4; i++) r_pm[i] <= w_new[i];
            r_dec    <= w_dec;
            r_en_mem <= 1'b1;
            r_count  <= r_count + CNT_W'(1);
            if (r_count == LAST_CNT) r_state <= DONE;
          end
        end
        DONE: begin
          r_frame_done <= 1'b1;
          r_best       <= w_best;
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign prv_st_00  = r_dec[0];
  assign prv_st_01  = r_dec[1];
  assign prv_st_10  = r_dec[2];
  assign prv_st_11  = r_dec[3];
  assign en_mem     = r_en_mem;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign best_st    = r_best;
  assign pm_00      = r_pm[0];
  assign pm_01      = r_pm[1];
  assign pm_10      = r_pm[2];
  assign pm_11      = r_pm[3];

endmodule

// File: tb/tb_acs_unit.sv
// tb/tb_acs_unit.sv - directed self-checking bench for acs_unit
// Three instances: 8-symbol frames (PM_W=6) and 64-symbol frames at PM_W=6 and PM_W=5.
module tb_acs_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_acs = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym = 2'b00;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] a_dec, b_dec, c_dec;
  logic       a_en_mem, a_busy, a_fd, b_en_mem, b_busy, b_fd, c_en_mem, c_busy, c_fd;
  logic [1:0] a_best, b_best, c_best;
  logic [5:0] a_pm [4];
  logic [5:0] b_pm [4];
  logic [4:0] c_pm [4];

  acs_unit #(.FRAME_LEN(8), .PM_W(6)) u_a (
    .clk(clk), .rst(rst), .en_acs(en_acs), .sym_valid(sym_valid), .sym(sym),
    .prv_st_00(a_dec[0]), .prv_st_01(a_dec[1]), .prv_st_10(a_dec[2]), .prv_st_11(a_dec[3]),
    .en_mem(a_en_mem), .busy(a_busy), .frame_done(a_fd), .best_st(a_best),
    .pm_00(a_pm[0]), .pm_01(a_pm[1]), .pm_10(a_pm[2]), .pm_11(a_pm[3]));

  acs_unit #(.FRAME_LEN(64), .PM_W(6)) u_b (
    .clk(clk), .rst(rst), .en_acs(en_acs), .sym_valid(sym_valid), .sym(sym),
    .prv_st_00(b_dec[0]), .prv_st_01(b_dec[1]), .prv_st_10(b_dec[2]), .prv_st_11(b_dec[3]),
    .en_mem(b_en_mem), .busy(b_busy), .frame_done(b_fd), .best_st(b_best),
    .pm_00(b_pm[0]), .pm_01(b_pm[1]), .pm_10(b_pm[2]), .pm_11(b_pm[3]));

  acs_unit #(.FRAME_LEN(64), .PM_W(5)) u_c (
    .clk(clk), .rst(rst), .en_acs(en_acs), .sym_valid(sym_valid), .sym(sym),
    .prv_st_00(c_dec[0]), .prv_st_01(c_dec[1]), .prv_st_10(c_dec[2]), .prv_st_11(c_dec[3]),
    .en_mem(c_en_mem), .busy(c_busy), .frame_done(c_fd), .best_st(c_best),
    .pm_00(c_pm[0]), .pm_01(c_pm[1]), .pm_10(c_pm[2]), .pm_11(c_pm[3]));

  // Reference trellis: k=0 unbounded, k=1 saturating at 63, k=2 saturating at 31.
  int         mdl [3][4];
  logic [3:0] mdec [3];
  logic [1:0] s35 [8];
  int         t_now, en_cnt, fd_cnt, last_en, fd_at, ob;
  logic [1:0] fd_best;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic ea, input logic sv, input logic [1:0] s);
    en_acs = ea;
    sym_valid = sv;
    sym = s;
    @(posedge clk);
    #1;
  endtask

  task automatic observe_a();
    t_now++;
    if (a_en_mem) begin en_cnt++; last_en = t_now; end
    if (a_fd) begin fd_cnt++; fd_at = t_now; fd_best = a_best; end
  endtask

  task automatic clear_obs();
    t_now = 0; en_cnt = 0; fd_cnt = 0; last_en = -1; fd_at = -100; fd_best = 2'b00;
  endtask

  function automatic logic [1:0] exp_sym(input int ns, input int b);
    case (ns * 2 + b)
      0: return 2'b00;
      1: return 2'b11;
      2: return 2'b10;
      3: return 2'b01;
      4: return 2'b11;
      5: return 2'b00;
      6: return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_step(input int k, input logic [1:0] s, input int maxv);
    int nw [4];
    int s0, s1, a;
    for (int ns = 0; ns < 4; ns++) begin
      a  = ns % 2;
      s0 = mdl[k][2*a]     + $countones(s ^ exp_sym(ns, 0));
      s1 = mdl[k][2*a + 1] + $countones(s ^ exp_sym(ns, 1));
      mdec[k][ns] = (s1 < s0);
      nw[ns] = (s1 < s0) ? s1 : s0;
      if (nw[ns] > maxv) nw[ns] = maxv;
    end
    for (int ns = 0; ns < 4; ns++) mdl[k][ns] = nw[ns];
  endtask

  function automatic logic [1:0] model_best(input int k);
    int b = 0;
    for (int i = 1; i < 4; i++) if (mdl[k][i] < mdl[k][b]) b = i;
    return 2'(b);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    s35 = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_pm00", a_pm[0], 0);
    chk("rst_pm01", a_pm[1], 16);
    chk("rst_pm11", a_pm[3], 16);
    chk("rst_en_mem", a_en_mem, 0);
    chk("rst_fd", a_fd, 0);
    chk("rst_best", a_best, 0);
    chk("rst_dec", a_dec, 0);
    rst = 1'b0;

    // sym_valid while idle is ignored
    cyc(0, 1, 2'b11);
    chk("idle_en_mem", a_en_mem, 0);
    chk("idle_busy", a_busy, 0);
    chk("idle_pm00", a_pm[0], 0);
    chk("idle_pm01", a_pm[1], 16);

    // All-zero frame, with an en_acs pulse mid-frame that must be ignored
    cyc(1, 0, 2'b00);
    chk("start_busy", a_busy, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'b00);
      chk("zero_en_mem", a_en_mem, 1);
      chk("zero_dec", a_dec, 0);
      if (i == 3) begin
        cyc(1, 0, 2'b00);
        chk("run_en_acs_en_mem", a_en_mem, 0);
        chk("run_en_acs_pm01", a_pm[1], 3);
        chk("run_en_acs_busy", a_busy, 1);
      end
    end
    cyc(0, 1, 2'b11);
    chk("zero_fd", a_fd, 1);
    chk("zero_best", a_best, 0);
    chk("zero_pm00", a_pm[0], 0);
    chk("done_en_mem", a_en_mem, 0);
    chk("done_pm01", a_pm[1], 3);
    cyc(0, 0, 2'b00);
    chk("zero_fd_clear", a_fd, 0);
    chk("zero_busy_clear", a_busy, 0);

    // Input 1,0,0,... encoded as 11,10,11,00,...
    cyc(1, 0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, s35[i]);
      if (i == 0) begin
        chk("v35_dec0", a_dec, 0);
        chk("v35_pm10_s1", a_pm[2], 0);
      end
      if (i == 1) begin
        chk("v35_pm01_s2", a_pm[1], 0);
        chk("v35_pm11_s2", a_pm[3], 2);
      end
      if (i == 2) chk("v35_dec2", a_dec, 4'hF);
    end
    cyc(0, 0, 2'b00);
    chk("v35_fd", a_fd, 1);
    chk("v35_best", a_best, 0);
    chk("v35_pm00", a_pm[0], 0);
    chk("v35_pm01", a_pm[1], 3);

    // Symbols 11 with 3-cycle gaps; final metrics 4,3,3,3 -> best 01 by tie rule
    cyc(1, 0, 2'b00);
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'b11);
      observe_a();
      if (i == 3) chk("gap_dec4", a_dec, 4'b1011);
      for (int g = 0; g < 3; g++) begin
        cyc(0, 0, 2'b11);
        observe_a();
      end
    end
    chk("gap_en_cnt", en_cnt, 8);
    chk("gap_fd_cnt", fd_cnt, 1);
    chk("gap_fd_lag", fd_at - last_en, 1);
    chk("gap_best", fd_best, 1);
    chk("gap_pm00", a_pm[0], 4);
    chk("gap_pm01", a_pm[1], 3);
    chk("gap_dec8", a_dec, 4'b0001);

    // Reset mid-frame after 4 symbols
    cyc(1, 0, 2'b00);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b11);
    chk("mid_pm01_pre", a_pm[1], 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_pm01", a_pm[1], 16);
    chk("mid_rst_en_mem", a_en_mem, 0);
    chk("mid_rst_dec", a_dec, 0);
    rst = 1'b0;
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 2'b11);
      observe_a();
    end
    chk("post_rst_en_cnt", en_cnt, 0);
    chk("post_rst_fd_cnt", fd_cnt, 0);
    cyc(1, 0, 2'b00);
    chk("restart_busy", a_busy, 1);
    chk("restart_pm01", a_pm[1], 16);
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 2'b11);
      observe_a();
    end
    cyc(0, 0, 2'b00);
    observe_a();
    chk("restart_en_cnt", en_cnt, 8);
    chk("restart_fd_cnt", fd_cnt, 1);
    chk("restart_best", fd_best, 1);
    chk("restart_pm00", a_pm[0], 4);

    // 64 symbols of 11 against the reference trellis
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) mdl[k] = '{0, 16, 16, 16};
    cyc(1, 0, 2'b00);
    for (int i = 0; i < 64; i++) begin
      model_step(0, 2'b11, 1 << 30);
      model_step(1, 2'b11, 63);
      model_step(2, 2'b11, 31);
      cyc(0, 1, 2'b11);
`ifdef ACS_NORM_EN
      chk("n64_b_dec", b_dec, mdec[0]);
      chk("n64_c_dec", c_dec, mdec[0]);
      ob = mdl[0][0] - int'(b_pm[0]);
      chk("n64_b_off_mod", ob % 32, 0);
      for (int j = 1; j < 4; j++) chk("n64_b_off", mdl[0][j] - int'(b_pm[j]), ob);
      ob = mdl[0][0] - int'(c_pm[0]);
      chk("n64_c_off_mod", ob % 16, 0);
      for (int j = 1; j < 4; j++) chk("n64_c_off", mdl[0][j] - int'(c_pm[j]), ob);
`else
      chk("s64_b_dec", b_dec, mdec[1]);
      chk("s64_c_dec", c_dec, mdec[2]);
      for (int j = 0; j < 4; j++) begin
        chk("s64_b_pm", b_pm[j], mdl[1][j]);
        chk("s64_c_pm", c_pm[j], mdl[2][j]);
      end
`endif
    end
    cyc(0, 0, 2'b00);
    chk("f64_b_fd", b_fd, 1);
    chk("f64_c_fd", c_fd, 1);
`ifdef ACS_NORM_EN
    chk("f64_b_best", b_best, model_best(0));
    chk("f64_c_best", c_best, model_best(0));
`else
    chk("f64_b_best", b_best, model_best(1));
    chk("f64_c_best", c_best, model_best(2));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acs_unit.md
ACS_UNIT -- requirements
Module: acs_unit

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 8, meaning symbols per frame; this equals the survivor-memory depth.
REQ-002 The block SHALL have parameter PM_W, default 6, meaning the path-metric width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port en_acs, input, 1 bit: frame start pulse.
REQ-006 The block SHALL have port sym_valid, input, 1 bit: received symbol qualifier.
REQ-007 The block SHALL have port sym, input, 2 bits: hard-decision received pair; sym[1] is the G0=111 bit and sym[0] is the G1=101 bit.
REQ-008 The block SHALL have ports prv_st_00, prv_st_01, prv_st_10 and prv_st_11, each output, 1 bit: survivor decision per state.
REQ-009 The block SHALL have port en_mem, output, 1 bit: decisions valid this cycle; it drives the survivor-memory write enable.
REQ-010 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-012 The block SHALL have port best_st, output, 2 bits: minimum-metric state, valid when frame_done=1.
REQ-013 The block SHALL have ports pm_00, pm_01, pm_10 and pm_11, each output, PM_W bits: registered path metrics.

Function
REQ-014 The code SHALL be rate 1/2 with K=3: state {s1,s0}, where s1 is the newest input bit; input u moves state {a,b} to {u,a}; expected output is c0=u^a^b and c1=u^b.
REQ-015 The predecessors of {u,a} SHALL be {a,0} and {a,1}; the decision bit SHALL be 1 if and only if {a,1} is selected.
REQ-016 The expected symbols SHALL be: into 00 from 00/01 = 00/11; into 01 from 10/11 = 10/01; into 10 from 00/01 = 11/00; into 11 from 10/11 = 01/10.
REQ-017 The branch metric SHALL be the Hamming distance between sym and the expected symbol, in the range 0..2.
REQ-018 Candidate sums SHALL be computed at PM_W+1 bits; on a tie the decision SHALL be 0.
REQ-019 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-020 In IDLE, busy=0; when en_acs=1 the FSM SHALL go to RUN, load pm_00=0 and the other metrics=16, and set count=0.
REQ-021 In RUN, busy=1; on each cycle with sym_valid=1 the block SHALL update all four metrics and decisions, pulse en_mem the following cycle (latency 1), and increment count.
REQ-022 In RUN, a cycle with sym_valid=0 SHALL hold metrics and keep en_mem=0.
REQ-023 When the FRAME_LEN-th symbol is accepted, the FSM SHALL go to DONE; in DONE it SHALL assert frame_done=1 for exactly 1 cycle with best_st = argmin of the metrics and then go to IDLE.
REQ-024 best_st ties SHALL resolve to the lowest state index.
REQ-025 en_acs in RUN or DONE SHALL be ignored.
REQ-026 sym_valid in IDLE or DONE SHALL be ignored, with no metric change and no en_mem.
REQ-027 Metrics and decisions SHALL hold their last values between frames.
REQ-028 count SHALL be $clog2(FRAME_LEN)+1 bits wide and SHALL never wrap within a frame.

Reset
REQ-029 While rst=1, the FSM SHALL be in IDLE, count=0, pm_00=0, and pm_01, pm_10, pm_11=16.
REQ-030 While rst=1, prv_st_* SHALL be 0, and en_mem, busy, frame_done and best_st SHALL be 0.
REQ-031 rst asserted mid-frame SHALL abort the frame immediately, with no frame_done and no further en_mem.

Configuration
REQ-032 When macro ACS_NORM_EN is defined, the block SHALL clear the MSB of all four new metrics in the same update whenever all four new metrics have MSB=1, i.e. subtract 2^(PM_W-1).
REQ-033 When ACS_NORM_EN is undefined, each new metric SHALL saturate at 2^PM_W-1 and there SHALL be no normalization.

Verification
REQ-034 The bench SHALL cover: en_acs, then 8 symbols 00 -> 8 en_mem pulses with all prv_st_*=0, then frame_done with best_st=00 and pm_00=0.
REQ-035 The bench SHALL cover: symbols 11,10,11,00,00,00,00,00 (input 1,0,0,...) -> frame_done with best_st=00 and pm_00=0; the first decision vector is prv_st_10=0.
REQ-036 The bench SHALL cover: sym_valid gaps of 3 cycles between symbols -> en_mem count=8, and frame_done 1 cycle after the last en_mem.
REQ-037 The bench SHALL cover: rst pulsed after the 4th symbol -> busy=0 and pm_01=16 at the next edge, with no frame_done; a new en_acs restarts cleanly.
REQ-038 The bench SHALL cover: FRAME_LEN=64 with 64 symbols of 11, ACS_NORM_EN undefined -> no metric exceeds 63 and no wrap.
REQ-039 The bench SHALL cover: the same stimulus as REQ-038 with ACS_NORM_EN defined -> decisions bit-identical to the unbounded golden model and all metrics < 64.
REQ-040 The bench SHALL cover: en_acs during RUN and sym_valid during IDLE -> no state change and no en_mem.
